// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction fetch block.
// Latency: none; this file holds only declarations.
// Backpressure: none; this file holds only declarations.
package imem_pkg;

  localparam int ADDR_W          = 64;
  localparam int INSTR_W         = 32;
  localparam int IMEM_BYTES_DFLT = 1024;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  // One prefetched word together with the byte address it was read from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_queue.sv
// Prefetch FIFO of fetch_entry_t with a flush that beats both push and pop.
// Latency: a pushed entry is visible at head one cycle after its push edge.
// Backpressure: push while full is accepted only together with a pop in the same cycle.
//
// Ports: clk/reset (sync, active-high); flush empties the queue at the edge;
//        push/push_dat write an entry; pop removes head when valid;
//        head/valid/full/count describe the current occupancy.
module fetch_queue
  import imem_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int PTR_W = $clog2(QDEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_dat,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic               valid,
  output logic               full,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == CNT_W'(QDEPTH));
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only observed once count covers it.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the combinational ROM, prefetches into a queue.
// Latency: a word reaches out_valid one cycle after its enqueue edge; redirect costs one bubble.
// Backpressure: out_* hold while out_valid && !out_ready; PC stalls when the queue is full.
//
// Ports: clk/reset (sync, active-high); imem_addr/imem_instr talk to the ROM;
//        redirect_valid/redirect_pc load a new PC and flush; out_valid/out_ready/
//        out_instr/out_pc hand words to decode; fault/fault_pc report a bad fetch;
//        fetch_count counts enqueued words, saturating.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int                 IMEM_BYTES = IMEM_BYTES_DFLT,
  parameter int                 QDEPTH     = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC   = 64'h0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_instr,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_pc,
  output logic                fault,
  output logic [ADDR_W-1:0]   fault_pc,
  output logic [31:0]         fetch_count
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  fetch_entry_t      q_head, q_push_dat;
  logic              q_valid, q_full, q_pop, do_enq, space, addr_bad;
  logic [CNT_W-1:0]  q_count;
  logic [ADDR_W:0]   pc_last;

  // One extra bit so pc+3 cannot wrap back into range near the top of memory.
  assign pc_last  = {1'b0, pc_q} + (ADDR_W+1)'(3);
  assign addr_bad = (pc_q[1:0] != 2'b00) || (pc_last >= (ADDR_W+1)'(IMEM_BYTES));

  assign q_pop = out_ready && (q_count != '0);
  // A full queue still takes a word when its head leaves in the same cycle.
  assign space = !q_full || q_pop;

  assign q_push_dat.instr = imem_instr;
  assign q_push_dat.pc    = pc_q;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (do_enq),
    .push_dat (q_push_dat),
    .pop      (q_pop),
    .head     (q_head),
    .valid    (q_valid),
    .full     (q_full),
    .count    (q_count)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q;
    do_enq        = 1'b0;
    if (redirect_valid) begin
      // Redirect wins from any state; a bad target is caught next cycle in RUN.
      state_d = RUN;
      fault_d = 1'b0;
      pc_d    = redirect_pc;
    end else begin
      unique case (state_q)
        RUN: begin
          if (addr_bad) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
          end else if (space) begin
            do_enq = 1'b1;
            pc_d   = pc_q + 64'd4;
            if (fetch_count_q != 32'hFFFF_FFFF) fetch_count_d = fetch_count_q + 32'd1;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = q_valid;
  assign out_instr   = q_valid ? q_head.instr : '0;
  assign out_pc      = q_valid ? q_head.pc    : '0;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = fetch_count_q;

endmodule
